// File: rtl/dds_bus_pkg.sv
// rtl/dds_bus_pkg.sv - shared states, timing defaults and DDS register map for the bus arbiter
package dds_bus_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_WAIT,
    ST_UPDATE
  } state_e;

  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_WR_CYC    = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;
  localparam int unsigned DEF_UD_CYC    = 4;
  localparam int unsigned DEF_MRST_CYC  = 8;

  localparam logic [4:0] ADDR_CTRL    = 5'h1F;
  localparam logic [4:0] ADDR_FTW1_LO = 5'h04;
  localparam logic [4:0] ADDR_FTW1_HI = 5'h09;
  localparam logic [4:0] ADDR_FTW2_LO = 5'h0A;
  localparam logic [4:0] ADDR_FTW2_HI = 5'h0F;
  localparam logic [4:0] ADDR_DFW_LO  = 5'h10;
  localparam logic [4:0] ADDR_DFW_HI  = 5'h15;
  localparam logic [4:0] ADDR_RAMP_LO = 5'h1A;
  localparam logic [4:0] ADDR_RAMP_HI = 5'h1C;

  // A state lasting n cycles is entered with the timer loaded to n-1.
  function automatic logic [7:0] dur_load(input int unsigned n);
    return 8'(n - 1);
  endfunction

endpackage

// File: rtl/dds_bus_timer.sv
// rtl/dds_bus_timer.sv - 8-bit loadable down-counter with zero flag, shared by all timed states
module dds_bus_timer (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] value_i,
  output logic       zero_o
);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = value_i;
    else if (cnt_q != 8'd0)
      cnt_d = cnt_q - 8'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/dds_bus_arbiter.sv
// rtl/dds_bus_arbiter.sv - two-requester round-robin arbiter sequencing AD9852-style parallel writes
module dds_bus_arbiter
  import dds_bus_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned WR_CYC    = DEF_WR_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned UD_CYC    = DEF_UD_CYC,
  parameter int unsigned MRST_CYC  = DEF_MRST_CYC
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic [4:0] addr0_i,
  input  logic [4:0] addr1_i,
  input  logic [7:0] data0_i,
  input  logic [7:0] data1_i,
  input  logic       last0_i,
  input  logic       last1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic       done0_o,
  output logic       done1_o,
  output logic [4:0] aout_o,
  output logic [7:0] dout_o,
  output logic       wrb_o,
  output logic       udclk_o,
  output logic       mreset_o,
  output logic       busy_o
);

  state_e     state_q, state_d;
  logic       gnt_q, pref_q, last_q, armed_q;
  logic       capture, cap_gnt, req_g, done_evt;
  logic       tmr_load, tmr_zero;
  logic [7:0] tmr_val;

  dds_bus_timer u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .load_i (tmr_load),
    .value_i(tmr_val),
    .zero_o (tmr_zero)
  );

  assign req_g    = gnt_q ? req1_i : req0_i;
  assign done_evt = (state_q == ST_UPDATE) && (state_d == ST_IDLE);

  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    cap_gnt  = gnt_q;
    tmr_load = 1'b0;
    tmr_val  = 8'd0;
    case (state_q)
      // First INIT cycle arms the timer, so MRESET spans exactly MRST_CYC cycles.
      ST_INIT: begin
        if (!armed_q) begin
          if (MRST_CYC <= 1) begin
            state_d = ST_IDLE;
          end else begin
            tmr_load = 1'b1;
            tmr_val  = 8'(MRST_CYC - 2);
          end
        end else if (tmr_zero) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (req0_i || req1_i) begin
          capture = 1'b1;
          cap_gnt = req1_i && (!req0_i || pref_q);
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          state_d  = ST_STROBE;
          tmr_load = 1'b1;
          tmr_val  = dur_load(WR_CYC);
        end
      end
      ST_STROBE: begin
        if (tmr_zero) begin
          state_d  = ST_HOLD;
          tmr_load = 1'b1;
          tmr_val  = dur_load(HOLD_CYC);
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          if (last_q) begin
            state_d  = ST_UPDATE;
            tmr_load = 1'b1;
            tmr_val  = dur_load(UD_CYC);
          end else if (req_g) begin
            capture = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (req_g) capture = 1'b1;
      end
      ST_UPDATE: begin
        if (tmr_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
    if (capture) begin
      state_d  = ST_SETUP;
      tmr_load = 1'b1;
      tmr_val  = dur_load(SETUP_CYC);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= ST_INIT;
      armed_q  <= 1'b0;
      gnt_q    <= 1'b0;
      pref_q   <= 1'b0;
      last_q   <= 1'b0;
      aout_o   <= 5'd0;
      dout_o   <= 8'd0;
      wrb_o    <= 1'b1;
      udclk_o  <= 1'b0;
      mreset_o <= 1'b1;
      ack0_o   <= 1'b0;
      ack1_o   <= 1'b0;
      done0_o  <= 1'b0;
      done1_o  <= 1'b0;
      busy_o   <= 1'b1;
    end else begin
      state_q  <= state_d;
      armed_q  <= 1'b1;
      ack0_o   <= capture && !cap_gnt;
      ack1_o   <= capture && cap_gnt;
      done0_o  <= done_evt && !gnt_q;
      done1_o  <= done_evt && gnt_q;
      wrb_o    <= (state_d != ST_STROBE);
      udclk_o  <= (state_d == ST_UPDATE);
      mreset_o <= (state_d == ST_INIT);
      busy_o   <= (state_d != ST_IDLE);
      if (capture) begin
        gnt_q  <= cap_gnt;
        aout_o <= cap_gnt ? addr1_i : addr0_i;
        dout_o <= cap_gnt ? data1_i : data0_i;
        last_q <= cap_gnt ? last1_i : last0_i;
      end
      if (done_evt) pref_q <= ~gnt_q;
    end
  end

endmodule

// File: tb/tb_dds_bus_arbiter.sv
// tb/tb_dds_bus_arbiter.sv - directed self-checking bench for dds_bus_arbiter
module tb_dds_bus_arbiter;
  import dds_bus_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, last0 = 1'b0, last1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, done0, done1, wrb, udclk, mreset, busy;
  logic [4:0] aout;
  logic [7:0] dout;

  int checks = 0;
  int failures = 0;

  dds_bus_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1),
    .addr0_i(addr0), .addr1_i(addr1),
    .data0_i(data0), .data1_i(data1),
    .last0_i(last0), .last1_i(last1),
    .ack0_o(ack0), .ack1_o(ack1),
    .done0_o(done0), .done1_o(done1),
    .aout_o(aout), .dout_o(dout),
    .wrb_o(wrb), .udclk_o(udclk),
    .mreset_o(mreset), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  logic       prev_wrb = 1'b1, prev_ud = 1'b0;
  logic [4:0] wr_a[$];
  logic [7:0] wr_d[$];
  int         wr_cyc[$];
  int         done_log[$];
  int         ud_rises = 0, ud_cyc = 0, ack0_cnt = 0, ack1_cnt = 0, done0_cnt = 0, done1_cnt = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (prev_wrb && !wrb) begin
      wr_a.push_back(aout);
      wr_d.push_back(dout);
      wr_cyc.push_back(cyc);
    end
    if (!prev_ud && udclk) begin
      ud_rises++;
      ud_cyc = cyc;
    end
    if (ack0) ack0_cnt++;
    if (ack1) ack1_cnt++;
    if (done0) begin done0_cnt++; done_log.push_back(0); end
    if (done1) begin done1_cnt++; done_log.push_back(1); end
    prev_wrb = wrb;
    prev_ud  = udclk;
  end

  task automatic clear_logs();
    wr_a.delete(); wr_d.delete(); wr_cyc.delete(); done_log.delete();
    ud_rises = 0; ack0_cnt = 0; ack1_cnt = 0; done0_cnt = 0; done1_cnt = 0;
  endtask

  task automatic set_req(input int r, input logic rq, input logic [4:0] a, input logic [7:0] d, input logic l);
    if (r == 0) begin req0 = rq; addr0 = a; data0 = d; last0 = l; end
    else        begin req1 = rq; addr1 = a; data1 = d; last1 = l; end
  endtask

  task automatic drive_burst(input int r, input int n, input logic [4:0] a[8], input logic [7:0] d[8]);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      logic got = 1'b0;
      set_req(r, 1'b1, a[i], d[i], i == n - 1);
      while (!got && t < 200) begin
        @(posedge clk); #1;
        t++;
        got = (r == 0) ? ack0 : ack1;
      end
      checks++;
      if (!got) begin failures++; $display("FAIL drive_ack r=%0d byte=%0d got=0 required=1", r, i); end
    end
    set_req(r, 1'b0, 5'd0, 8'd0, 1'b0);
  endtask

  task automatic count_mreset(input string tag);
    int n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!mreset) break;
    end
    checks++;
    if (n != 8) begin failures++; $display("FAIL %s mreset_cycles got=%0d required=8", tag, n); end
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, ADDR_CTRL, 8'h10, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wrb, mreset, busy, udclk, aout, dout, ack0, done0} !== {1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_values wrb=%b mreset=%b busy=%b udclk=%b aout=%h dout=%h required 1 1 1 0 00 00", wrb, mreset, busy, udclk, aout, dout);
    end
    rst = 1'b0;
    count_mreset("init");
    checks++;
    if (ack0_cnt != 0) begin failures++; $display("FAIL init_no_ack ack0_count=%0d required=0", ack0_cnt); end
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b1) begin failures++; $display("FAIL idle_capture_latency ack0=%b required=1", ack0); end
    set_req(0, 1'b0, 5'd0, 8'd0, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    checks++;
    if (done0_cnt != 1 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_first_burst done0=%0d busy=%b required 1 0", done0_cnt, busy);
    end
  endtask

  task automatic test_one_byte();
    logic [11:0] exp_wrb, exp_ud, exp_done;
    exp_wrb  = 12'b1111_1111_1001;
    exp_ud   = 12'b0000_1111_0000;
    exp_done = 12'b0001_0000_0000;
    clear_logs();
    set_req(0, 1'b1, ADDR_CTRL, 8'h10, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (ack0 !== 1'b1) begin failures++; $display("FAIL one_ack0 got=%b required=1", ack0); end
    set_req(0, 1'b0, 5'd0, 8'd0, 1'b0);
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (wrb !== exp_wrb[k] || udclk !== exp_ud[k] || done0 !== exp_done[k]) begin
        failures++;
        $display("FAIL one_wave k=%0d wrb/ud/done=%b%b%b required=%b%b%b", k, wrb, udclk, done0, exp_wrb[k], exp_ud[k], exp_done[k]);
      end
      if (k < 4) begin
        checks++;
        if (aout !== 5'h1F || dout !== 8'h10) begin
          failures++; $display("FAIL one_bus k=%0d aout=%h dout=%h required=1f 10", k, aout, dout);
        end
      end
    end
    checks++;
    if (ack1_cnt != 0 || done1_cnt != 0 || done0_cnt != 1) begin
      failures++; $display("FAIL one_counts ack1=%0d done1=%0d done0=%0d required 0 0 1", ack1_cnt, done1_cnt, done0_cnt);
    end
  endtask

  task automatic test_ftw1_burst();
    logic [4:0] a[8];
    logic [7:0] d[8];
    logic [7:0] dv[6];
    int t = 0;
    dv[0] = 8'h11; dv[1] = 8'h22; dv[2] = 8'h33; dv[3] = 8'h44; dv[4] = 8'h55; dv[5] = 8'h66;
    for (int i = 0; i < 8; i++) begin
      a[i] = (i < 6) ? 5'(ADDR_FTW1_HI - 5'(i)) : 5'd0;
      d[i] = (i < 6) ? dv[i] : 8'd0;
    end
    clear_logs();
    drive_burst(0, 6, a, d);
    while (done0_cnt == 0 && t < 60) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    checks++;
    if (wr_a.size() != 6) begin
      failures++; $display("FAIL ftw1_writes got=%0d required=6", wr_a.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wr_a[i] !== 5'(5'h09 - 5'(i)) || wr_d[i] !== dv[i]) begin
          failures++; $display("FAIL ftw1_byte%0d aout=%h dout=%h required=%h %h", i, wr_a[i], wr_d[i], 5'(5'h09 - 5'(i)), dv[i]);
        end
        if (i > 0) begin
          checks++;
          if (wr_cyc[i] - wr_cyc[i-1] != 4) begin
            failures++; $display("FAIL ftw1_gap%0d got=%0d required=4", i, wr_cyc[i] - wr_cyc[i-1]);
          end
        end
      end
      checks++;
      if (ud_cyc - wr_cyc[0] != 23) begin
        failures++; $display("FAIL ftw1_ud_time got=%0d required=23", ud_cyc - wr_cyc[0]);
      end
    end
    checks++;
    if (ud_rises != 1 || done0_cnt != 1) begin
      failures++; $display("FAIL ftw1_update ud_rises=%0d done0=%0d required 1 1", ud_rises, done0_cnt);
    end
  endtask

  task automatic test_arbitration();
    logic [4:0] a0[8], a1[8];
    logic [7:0] d0[8], d1[8];
    logic [4:0] ea[8];
    logic [7:0] ed[8];
    for (int i = 0; i < 8; i++) begin a0[i] = 5'd0; a1[i] = 5'd0; d0[i] = 8'd0; d1[i] = 8'd0; end
    a0[0] = 5'h0A; a0[1] = 5'h0B; d0[0] = 8'h01; d0[1] = 8'h02;
    a1[0] = 5'h10; a1[1] = 5'h11; d1[0] = 8'h81; d1[1] = 8'h82;
    ea[0] = 5'h0A; ea[1] = 5'h0B; ea[2] = 5'h10; ea[3] = 5'h11;
    ed[0] = 8'h01; ed[1] = 8'h02; ed[2] = 8'h81; ed[3] = 8'h82;
    for (int i = 4; i < 8; i++) begin ea[i] = ea[i-4]; ed[i] = ed[i-4]; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    count_mreset("arb_reinit");
    clear_logs();
    for (int rnd = 0; rnd < 2; rnd++) begin
      int t = 0;
      fork
        drive_burst(0, 2, a0, d0);
        drive_burst(1, 2, a1, d1);
      join
      while (done_log.size() < 2 * (rnd + 1) && t < 60) begin @(posedge clk); #1; t++; end
    end
    checks++;
    if (done_log.size() != 4) begin
      failures++; $display("FAIL arb_done_count got=%0d required=4", done_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (done_log[i] != (i % 2)) begin
          failures++; $display("FAIL arb_order%0d got=%0d required=%0d", i, done_log[i], i % 2);
        end
      end
    end
    checks++;
    if (wr_a.size() != 8) begin
      failures++; $display("FAIL arb_writes got=%0d required=8", wr_a.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (wr_a[i] !== ea[i] || wr_d[i] !== ed[i]) begin
          failures++; $display("FAIL arb_byte%0d aout=%h dout=%h required=%h %h", i, wr_a[i], wr_d[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_wait();
    logic [9:0] exp_wrb;
    int t;
    exp_wrb = 10'b11_1111_1001;
    clear_logs();
    set_req(1, 1'b1, ADDR_RAMP_LO, 8'h5A, 1'b0);
    t = 0;
    while (!ack1 && t < 20) begin @(posedge clk); #1; t++; end
    checks++;
    if (!ack1) begin failures++; $display("FAIL wait_first_ack got=0 required=1"); end
    set_req(1, 1'b0, 5'd0, 8'd0, 1'b0);
    set_req(0, 1'b1, ADDR_CTRL, 8'h77, 1'b1);
    for (int k = 0; k < 10; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      checks++;
      if (wrb !== exp_wrb[k] || busy !== 1'b1) begin
        failures++; $display("FAIL wait_wave k=%0d wrb=%b busy=%b required=%b 1", k, wrb, busy, exp_wrb[k]);
      end
    end
    checks++;
    if (ack0_cnt != 0 || ud_rises != 0) begin
      failures++; $display("FAIL wait_blocked ack0=%0d ud_rises=%0d required 0 0", ack0_cnt, ud_rises);
    end
    set_req(1, 1'b1, 5'h1B, 8'hA5, 1'b1);
    t = 0;
    while (!ack1 && t < 20) begin @(posedge clk); #1; t++; end
    checks++;
    if (!ack1) begin failures++; $display("FAIL wait_resume_ack got=0 required=1"); end
    set_req(1, 1'b0, 5'd0, 8'd0, 1'b0);
    t = 0;
    while (!done1 && t < 30) begin @(posedge clk); #1; t++; end
    checks++;
    if (!done1 || ack0_cnt != 0) begin
      failures++; $display("FAIL wait_done1 done1=%b ack0=%0d required 1 0", done1, ack0_cnt);
    end
    t = 0;
    while (!ack0 && t < 20) begin @(posedge clk); #1; t++; end
    set_req(0, 1'b0, 5'd0, 8'd0, 1'b0);
    t = 0;
    while (!done0 && t < 30) begin @(posedge clk); #1; t++; end
    checks++;
    if (!done0) begin failures++; $display("FAIL wait_req0_served done0=0 required=1"); end
    checks++;
    if (wr_a.size() != 3 || wr_a[0] !== 5'h1A || wr_d[0] !== 8'h5A || wr_a[1] !== 5'h1B ||
        wr_d[1] !== 8'hA5 || wr_a[2] !== 5'h1F || wr_d[2] !== 8'h77) begin
      failures++; $display("FAIL wait_writes count=%0d required 3 writes 1a/5a 1b/a5 1f/77", wr_a.size());
    end
  endtask

  task automatic test_reset_mid_strobe();
    int t = 0;
    set_req(0, 1'b1, ADDR_CTRL, 8'h3C, 1'b1);
    while (!ack0 && t < 20) begin @(posedge clk); #1; t++; end
    set_req(0, 1'b0, 5'd0, 8'd0, 1'b0);
    @(posedge clk); #1;
    checks++;
    if (wrb !== 1'b0) begin failures++; $display("FAIL mid_strobe wrb=%b required=0", wrb); end
    rst = 1'b1;
    #1;
    checks++;
    if ({wrb, udclk, mreset, aout, busy} !== {1'b1, 1'b0, 1'b1, 5'd0, 1'b1}) begin
      failures++; $display("FAIL mid_reset wrb=%b udclk=%b mreset=%b aout=%h busy=%b required 1 0 1 00 1", wrb, udclk, mreset, aout, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    count_mreset("mid_reinit");
  endtask

  initial begin
    test_reset();
    test_one_byte();
    test_ftw1_burst();
    test_arbitration();
    test_wait();
    test_reset_mid_strobe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/dds_bus_arbiter.md
# dds_bus_arbiter

Arbitrates two register-write requesters for the single AD9852-style DDS parallel port and sequences every bus write with programmable setup/strobe/hold timing. Requester 0 is the host configuration writer (frequency/mode words); requester 1 is the sweep/FSK retuning engine. After each complete burst the block issues the DDS update-clock pulse. It also owns the DDS master-reset sequence at power-up. It is the only driver of AOUT/DOUT/WRB/UDCLK/MRESET in the design.

## Interface
- SETUP_CYC, 1: cycles AOUT/DOUT are stable before WRB falls (1..255)
- WR_CYC, 2: cycles WRB is held low (1..255)
- HOLD_CYC, 1: cycles AOUT/DOUT are held after WRB rises (1..255)
- UD_CYC, 4: UDCLK high width in cycles (1..255)
- MRST_CYC, 8: MRESET high width after reset release (1..255)
- CLK  in  1  system clock, rising edge
- RST  in  1  asynchronous reset, active-high
- REQ0, REQ1  in  1  burst request from requester 0 / 1
- ADDR0, ADDR1  in  5  DDS register address of the presented byte
- DATA0, DATA1  in  8  byte presented
- LAST0, LAST1  in  1  presented byte is the final byte of the burst
- ACK0, ACK1  out  1  one-cycle pulse: presented byte captured
- DONE0, DONE1  out  1  one-cycle pulse: burst written and UDCLK completed
- AOUT  out  5  DDS address bus
- DOUT  out  8  DDS data bus
- WRB  out  1  DDS write strobe, active-low
- UDCLK  out  1  DDS I/O update clock
- MRESET  out  1  DDS master reset, active-high
- BUSY  out  1  high in every state except IDLE

## Operation
- States: INIT, IDLE, SETUP, STROBE, HOLD, WAIT, UPDATE.
- RST asserted (asynchronous): state INIT, counter 0, AOUT=0, DOUT=0, WRB=1, UDCLK=0, MRESET=1, ACKx=0, DONEx=0, BUSY=1, round-robin pointer favours requester 0.
- INIT: MRESET stays high for MRST_CYC cycles after RST falls, then MRESET=0 → IDLE. REQx is ignored in INIT.
- IDLE: if any REQx is high, grant is decided and the byte is captured on the same edge. AOUT/DOUT are loaded, ACKx pulses on the next cycle, and the state goes to SETUP. If both requesters are high, the one not served by the previous burst wins; after reset, requester 0 wins.
- SETUP (SETUP_CYC) → STROBE with WRB=0 (WR_CYC) → HOLD with WRB=1 (HOLD_CYC).
- End of HOLD:
  - If the captured LAST was set → UPDATE.
  - Otherwise, if REQ of the grantee is high, capture the next byte on that edge → SETUP.
  - Otherwise → WAIT.
- WAIT: the grant is held and the other requester is blocked. There is no timeout. The state exits when the grantee's REQ rises, using the same capture as from IDLE.
- UPDATE: UDCLK=1 for UD_CYC cycles. On the edge UDCLK falls, DONEx pulses for one cycle, the grant is released, the round-robin pointer is toggled, and the state goes to IDLE.
- AOUT/DOUT keep their last value outside SETUP/STROBE/HOLD.
- Requester protocol: keep REQ, ADDR, DATA and LAST stable until ACK is seen. Change them on the edge after ACK. Inputs are not sampled again until at least SETUP+WR+HOLD cycles later.
- The non-granted requester's ACK and DONE stay 0.

## Timing
- Capture edge E0: AOUT/DOUT valid after E0.
- WRB falls at E0+SETUP_CYC.
- WRB rises at E0+SETUP_CYC+WR_CYC.
- Next capture or UPDATE entry at E0+SETUP_CYC+WR_CYC+HOLD_CYC; with defaults, 4 cycles per byte.
- REQ high in IDLE → capture on the first rising edge (1-cycle latency).
- N-byte burst with defaults, no gaps:
  - UDCLK rises 4N cycles after the first capture.
  - DONE pulses at 4N+4.
  - IDLE is re-entered at 4N+4, and a new capture is possible at 4N+5.
- All outputs are registered; no combinational input→output paths.

## Structure
- Shared package dds_bus_pkg holds:
  - the state enum;
  - default timing constants;
  - DDS register address constants: 5'h1F control, 5'h04–5'h09 FTW1, 5'h0A–5'h0F FTW2, 5'h10–5'h15 delta-frequency word, 5'h1A–5'h1C ramp rate.
- One sub-module, dds_bus_timer: an 8-bit down-counter with load/value inputs and a zero flag, reused for every timed state.

## Test plan
- Reset release: MRESET high for exactly 8 cycles. REQ0 held high during INIT gets no ACK0 until IDLE.
- REQ0 one-byte burst (ADDR 5'h1F, DATA 8'h10, LAST=1):
  - AOUT=1F and DOUT=10 for 4 cycles;
  - WRB low for cycles 2–3;
  - UDCLK high for 4 cycles;
  - DONE0 once; ACK1 and DONE1 stay 0.
- REQ0 six-byte FTW1 burst (09..04): six WRB pulses 4 cycles apart with matching AOUT/DOUT, and a single UDCLK at the end.
- REQ0 and REQ1 raised on the same cycle, each with a two-byte burst:
  - requester 0 is served first, then requester 1;
  - repeated simultaneous requests alternate 0, 1, 0, 1.
- REQ1 is dropped after its first non-LAST byte for 10 cycles while REQ0 is high:
  - the state enters WAIT and WRB stays high;
  - REQ0 gets no ACK0;
  - the burst resumes when REQ1 returns.
- RST asserted mid-STROBE: on the same edge WRB=1, UDCLK=0, MRESET=1 and AOUT=0; after release the INIT sequence repeats.
